// File: rtl/nf2_dma_pkt_fifo_pkg.sv
// Shared definitions for the sys_clk-side DMA packet FIFO:
// word field layout helpers and the drop state machine encoding.
package nf2_dma_pkt_fifo_pkg;

    // Default payload width of a DMA word.
    localparam int DMA_DATA_WIDTH = 32;

    // Drop state machine: DROP_DROPPING swallows the rest of an overflowed packet.
    typedef enum logic {
        DROP_IDLE     = 1'b0,
        DROP_DROPPING = 1'b1
    } drop_state_e;

    // Word layout is {eop, bytecnt, data}; eop sits in the top bit.
    function automatic int eop_bit(input int data_width, input int bcnt_width);
        return data_width + bcnt_width;
    endfunction

endpackage

// File: rtl/nf2_dma_pkt_fifo_if.sv
// Write/read port bundle of the DMA packet FIFO.
//
// Handshake: a word is written on a cycle with wr_en=1 while full=0 (and no
// packet is being discarded); a head word is consumed on a cycle with rd_inc=1
// while empty=0. rd_data is valid whenever empty=0. wr_en while full and
// rd_inc while empty are not back-pressured errors: the former is reported
// with a one-cycle drop pulse, the latter is ignored.
interface nf2_dma_pkt_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BCNT_WIDTH = 2,
    parameter int DEPTH_BITS = 3
);
    localparam int WORD_W = DATA_WIDTH + BCNT_WIDTH + 1;

    logic [WORD_W-1:0]   wr_data;
    logic                wr_en;
    logic                full;
    logic                nearly_full;
    logic [WORD_W-1:0]   rd_data;
    logic                rd_inc;
    logic                empty;
    logic                pkt_avail;
    logic [DEPTH_BITS:0] pkt_cnt;
    logic                drop;

    modport master (
        output wr_data, wr_en, rd_inc,
        input  full, nearly_full, rd_data, empty, pkt_avail, pkt_cnt, drop
    );

    modport slave (
        input  wr_data, wr_en, rd_inc,
        output full, nearly_full, rd_data, empty, pkt_avail, pkt_cnt, drop
    );
endinterface

// File: rtl/nf2_dma_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module nf2_dma_fifo_ram #(
    parameter int WIDTH     = 35,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);
    logic [WIDTH-1:0] mem_q [2**ADDR_BITS];

    // Store the incoming word at the write slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/nf2_dma_pkt_fifo.sv
// Single-clock DMA packet FIFO with optional store-and-forward and
// drop-on-overflow. Holds the pointers, packet count, drop FSM and flags;
// storage lives in nf2_dma_fifo_ram.
module nf2_dma_pkt_fifo
    import nf2_dma_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH        = DMA_DATA_WIDTH,
    parameter int BCNT_WIDTH        = 2,
    parameter int DEPTH_BITS        = 3,
    parameter int NEARLY_FULL_SLACK = 2,
    parameter int PKT_MODE          = 1
) (
    input  logic                sys_clk,
    input  logic                sys_reset,
    nf2_dma_pkt_fifo_if.slave   fifo,
    output drop_state_e         dbg_drop_state
);
    localparam int WORD_W  = DATA_WIDTH + BCNT_WIDTH + 1;
    localparam int EOP_BIT = eop_bit(DATA_WIDTH, BCNT_WIDTH);

    typedef logic [DEPTH_BITS:0] ptr_t;

    localparam ptr_t CAPACITY = ptr_t'(2**DEPTH_BITS);
    localparam ptr_t SLACK    = ptr_t'(NEARLY_FULL_SLACK);

    ptr_t        wr_cur_q, wr_cur_d;
    ptr_t        wr_commit_q, wr_commit_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        pkt_cnt_q, pkt_cnt_d;
    logic        drop_q, drop_d;
    drop_state_e state_q, state_d;

    ptr_t              used;
    logic              full;
    logic              empty;
    logic              wr_eop;
    logic              rd_eop;
    logic              wr_accept;
    logic              rd_pop;
    logic [WORD_W-1:0] ram_rdata;

    // Flags come only from registered pointers, so a pop frees space a cycle later.
    assign used      = wr_cur_q - rd_ptr_q;
    assign full      = (used == CAPACITY);
    assign empty     = (rd_ptr_q == wr_commit_q);
    assign wr_eop    = fifo.wr_data[EOP_BIT];
    assign rd_eop    = ram_rdata[EOP_BIT];
    assign wr_accept = fifo.wr_en && !full && (state_q == DROP_IDLE);
    assign rd_pop    = fifo.rd_inc && !empty;

    // Next-state for pointers, packet count, drop pulse and drop FSM.
    always_comb begin
        wr_cur_d    = wr_cur_q;
        wr_commit_d = wr_commit_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_cnt_d   = pkt_cnt_q;
        drop_d      = 1'b0;
        state_d     = state_q;

        if (wr_accept) begin
            wr_cur_d = wr_cur_q + 1'b1;
            // Word mode publishes every word; packet mode only on end of packet.
            if (PKT_MODE == 0 || wr_eop) begin
                wr_commit_d = wr_cur_q + 1'b1;
            end
        end

        if (rd_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            DROP_IDLE: begin
                if (fifo.wr_en && full) begin
                    drop_d = 1'b1;
                    if (PKT_MODE != 0) begin
                        // Rewind the partial packet; keep swallowing it unless this was its last word.
                        wr_cur_d = wr_commit_q;
                        if (!wr_eop) begin
                            state_d = DROP_DROPPING;
                        end
                    end
                end
            end
            DROP_DROPPING: begin
                if (fifo.wr_en && wr_eop) begin
                    state_d = DROP_IDLE;
                end
            end
            default: state_d = DROP_IDLE;
        endcase

        case ({wr_accept && wr_eop, rd_pop && rd_eop})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    // State registers with synchronous reset; reset discards all stored words.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            wr_cur_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            drop_q      <= 1'b0;
            state_q     <= DROP_IDLE;
        end else begin
            wr_cur_q    <= wr_cur_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_q      <= drop_d;
            state_q     <= state_d;
        end
    end

    nf2_dma_fifo_ram #(
        .WIDTH     (WORD_W),
        .ADDR_BITS (DEPTH_BITS)
    ) u_ram (
        .clk   (sys_clk),
        .we    (wr_accept),
        .waddr (wr_cur_q[DEPTH_BITS-1:0]),
        .wdata (fifo.wr_data),
        .raddr (rd_ptr_q[DEPTH_BITS-1:0]),
        .rdata (ram_rdata)
    );

    assign fifo.rd_data     = ram_rdata;
    assign fifo.full        = full;
    assign fifo.nearly_full = ((CAPACITY - used) <= SLACK);
    assign fifo.empty       = empty;
    assign fifo.pkt_cnt     = pkt_cnt_q;
    assign fifo.pkt_avail   = (pkt_cnt_q != '0);
    assign fifo.drop        = drop_q;
    assign dbg_drop_state   = state_q;
endmodule
